// File: rtl/alu_pipe_pkg.sv
// Opcode encodings, flag bit positions and the opcode type shared by the ALU core,
// the pin-mux wrapper and the bench.
package alu_pipe_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'd0;
  localparam alu_op_t OP_SUB = 3'd1;
  localparam alu_op_t OP_AND = 3'd2;
  localparam alu_op_t OP_OR  = 3'd3;
  localparam alu_op_t OP_XOR = 3'd4;
  localparam alu_op_t OP_MUL = 3'd5;
  localparam alu_op_t OP_SHL = 3'd6;
  localparam alu_op_t OP_CMP = 3'd7;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/alu_pipe_exec.sv
// Purely combinational op/flag unit: computes {hi, res} and {ovf, carry, zero} for one beat.
module alu_pipe_exec
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] hi,
  output logic [2:0]       flags
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shl_ext;
  logic [SW-1:0]      sh;
  logic               carry;
  logic               ovf;

  // Shift is done one bit wider so bit WIDTH holds the last bit pushed out of the result.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sh      = b[SW-1:0];
    shl_ext = {1'b0, a} << sh;
    res     = '0;
    hi      = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        hi  = prod[2*WIDTH-1:WIDTH];
      end
      OP_SHL: begin
        res   = shl_ext[WIDTH-1:0];
        carry = shl_ext[WIDTH];
      end
      OP_CMP: res = {{(WIDTH-1){1'b0}}, (a >= b)};
      default: ;
    endcase
    flags            = '0;
    flags[FLG_ZERO]  = ({hi, res} == '0);
    flags[FLG_CARRY] = carry;
    flags[FLG_OVF]   = ovf;
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Pipelined ALU core: exec unit feeding STAGES register slices under one global stall.
// Optional accumulator operand enabled by defining ALU_ACC_EN.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef ALU_ACC_EN
  input  logic             in_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [WIDTH-1:0] out_hi,
  output logic [2:0]       out_flags
);

  logic [STAGES-1:0] stg_valid;
  logic [WIDTH-1:0]  stg_res   [STAGES];
  logic [WIDTH-1:0]  stg_hi    [STAGES];
  logic [2:0]        stg_flags [STAGES];

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] exe_res;
  logic [WIDTH-1:0] exe_hi;
  logic [2:0]       exe_flags;

  assign advance = !out_valid || out_ready;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc;

  // Accumulator beats wait for an empty pipe so acc already holds the newest result.
  assign in_ready = advance && !(in_valid && in_acc && (|stg_valid));
  assign op_a     = in_acc ? acc : in_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      acc <= out_res;
    end
  end
`else
  assign in_ready = advance;
  assign op_a     = in_a;
`endif

  assign accept = in_valid && in_ready;

  alu_pipe_exec #(
    .WIDTH (WIDTH)
  ) u_exec (
    .op    (in_op),
    .a     (op_a),
    .b     (in_b),
    .res   (exe_res),
    .hi    (exe_hi),
    .flags (exe_flags)
  );

  // Every slice, bubbles included, moves only when the output side can drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stg_res[i]   <= '0;
        stg_hi[i]    <= '0;
        stg_flags[i] <= '0;
      end
    end else if (advance) begin
      stg_valid[0] <= accept;
      stg_res[0]   <= exe_res;
      stg_hi[0]    <= exe_hi;
      stg_flags[0] <= exe_flags;
      for (int i = 1; i < STAGES; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_res[i]   <= stg_res[i-1];
        stg_hi[i]    <= stg_hi[i-1];
        stg_flags[i] <= stg_flags[i-1];
      end
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign out_res   = stg_res[STAGES-1];
  assign out_hi    = stg_hi[STAGES-1];
  assign out_flags = stg_flags[STAGES-1];

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core: accepted beats push model results, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_pipe_core;
  import alu_pipe_pkg::*;

  localparam int     WIDTH  = 8;
  localparam int     STAGES = 2;
  localparam longint MOD    = 64'd1 << WIDTH;
  localparam longint HALF   = MOD / 2;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic [2:0]       flags;
    int               issue_cyc;
    bit               chk_lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_acc = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_res;
  logic [WIDTH-1:0] out_hi;
  logic [2:0]       out_flags;

  int               n_checks = 0;
  int               n_pass = 0;
  int               cycle = 0;
  int               ready_mode = 0;
  bit               toggle = 1'b0;
  bit               lat_mode = 1'b0;
  bit               held = 1'b0;
  logic [WIDTH-1:0] held_res;
  logic [WIDTH-1:0] held_hi;
  logic [2:0]       held_flags;
  logic [WIDTH-1:0] acc_model = '0;
  exp_t             exp_q[$];
  exp_t             mon_e;

  alu_pipe_core #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef ALU_ACC_EN
    .in_acc    (in_acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_hi    (out_hi),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // out_ready pattern: 0 always high, 1 alternating, 2 random, otherwise low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = toggle;
        toggle    = ~toggle;
      end
      2: out_ready = ($urandom_range(0, 99) < 60);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Reference model straight from the op definitions, using plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input longint a, input longint b);
    exp_t   e;
    longint r, h, sa, sb, s;
    bit     c, v;
    int     sh;
    r  = 0;
    h  = 0;
    c  = 0;
    v  = 0;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    case (op)
      OP_ADD: begin
        r = (a + b) % MOD;
        c = (a + b) >= MOD;
        s = sa + sb;
        v = (s >= HALF) || (s < -HALF);
      end
      OP_SUB: begin
        r = (a - b + MOD) % MOD;
        c = a < b;
        s = sa - sb;
        v = (s >= HALF) || (s < -HALF);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_MUL: begin
        r = (a * b) % MOD;
        h = (a * b) / MOD;
      end
      OP_SHL: begin
        sh = int'(b % (64'd1 << $clog2(WIDTH)));
        r  = (a << sh) % MOD;
        c  = (sh > 0) ? ((a >> (WIDTH - sh)) & 1) != 0 : 1'b0;
      end
      default: r = (a >= b) ? 1 : 0;
    endcase
    e.res       = WIDTH'(r);
    e.hi        = WIDTH'(h);
    e.flags     = {v, c, (r == 0 && h == 0)};
    e.issue_cyc = 0;
    e.chk_lat   = 1'b0;
    return e;
  endfunction

  // Monitor: pops on every output handshake, checks held outputs, pushes on every accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held      = 1'b0;
      acc_model = '0;
    end else begin
      if (held) begin
        check_output("hold_valid", out_valid, 1);
        check_output("hold_res", out_res, held_res);
        check_output("hold_hi", out_hi, held_hi);
        check_output("hold_flags", out_flags, held_flags);
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_out", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("res", out_res, mon_e.res);
          check_output("hi", out_hi, mon_e.hi);
          check_output("flags", out_flags, mon_e.flags);
          if (mon_e.chk_lat) check_output("latency", cycle - mon_e.issue_cyc, STAGES);
        end
      end else if (out_valid) begin
        held       = 1'b1;
        held_res   = out_res;
        held_hi    = out_hi;
        held_flags = out_flags;
      end
      if (in_valid && in_ready) begin
        mon_e           = model(in_op, in_acc ? acc_model : in_a, in_b);
        mon_e.issue_cyc = cycle;
        mon_e.chk_lat   = lat_mode;
        exp_q.push_back(mon_e);
        acc_model = mon_e.res;
      end
    end
  end

  task automatic apply_stimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic acc);
    int tries;
    bit ok;
    tries    = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!ok) check_output("accept_timeout", ok, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_acc   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return WIDTH'(HALF);
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic check_reset_outputs();
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_res", out_res, 0);
    check_output("rst_out_hi", out_hi, 0);
    check_output("rst_out_flags", out_flags, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ready_mode = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed corners at full rate, latency checked on each.
    lat_mode = 1'b1;
    apply_stimulus(OP_ADD, 8'd200, 8'd100, 1'b0);
    apply_stimulus(OP_MUL, 8'd16,  8'd16,  1'b0);
    apply_stimulus(OP_SUB, 8'd3,   8'd5,   1'b0);
    apply_stimulus(OP_CMP, 8'd8,   8'd12,  1'b0);
    apply_stimulus(OP_CMP, 8'd12,  8'd8,   1'b0);
    apply_stimulus(OP_SHL, 8'd7,   8'd1,   1'b0);
    apply_stimulus(OP_SHL, 8'h81,  8'd7,   1'b0);
    apply_stimulus(OP_AND, 8'hF0,  8'h0F,  1'b0);
    apply_stimulus(OP_ADD, 8'd127, 8'd1,   1'b0);
    apply_stimulus(OP_SUB, 8'd128, 8'd1,   1'b0);
    apply_stimulus(OP_XOR, 8'h5A,  8'hFF,  1'b0);
    apply_stimulus(OP_OR,  8'h00,  8'h00,  1'b0);
    idle(STAGES + 3);
    lat_mode = 1'b0;

    // Back-to-back stream against an alternating out_ready.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'b0);
    end
    idle(12);

    // Random traffic with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      in_op    = 3'($urandom_range(0, 7));
      in_a     = rand_operand();
      in_b     = rand_operand();
      in_acc   = 1'b0;
`ifdef ALU_ACC_EN
      in_acc   = ($urandom_range(0, 3) == 0);
`endif
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    idle(STAGES + 4);

`ifdef ALU_ACC_EN
    apply_stimulus(OP_ADD, 8'd5, 8'd0, 1'b0);
    apply_stimulus(OP_ADD, 8'd0, 8'd3, 1'b1);
    idle(STAGES + 3);
`endif

    // Reset with two beats in flight; nothing may emerge afterwards.
    apply_stimulus(OP_ADD, 8'd1, 8'd2, 1'b0);
    apply_stimulus(OP_MUL, 8'd9, 8'd9, 1'b0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_midreset", in_ready, 1);
    for (int i = 0; i < STAGES + 3; i++) begin
      @(negedge clk);
      check_output("post_reset_idle", out_valid, 0);
    end

    apply_stimulus(OP_ADD, 8'd200, 8'd100, 1'b0);
    idle(1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_output("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
